// File: rtl/apple_bridge_pkg.sv
// Shared register-select codes and write-FSM state type for the Apple II bridge responder.
package apple_bridge_pkg;
   localparam logic [2:0] SEL_CTRL    = 3'd0;
   localparam logic [2:0] SEL_DATA    = 3'd1;
   localparam logic [2:0] SEL_ADDR_LO = 3'd2;
   localparam logic [2:0] SEL_ADDR_HI = 3'd3;
   localparam logic [2:0] SEL_M2      = 3'd4;
   localparam logic [2:0] SEL_DIP     = 3'd5;
   localparam logic [2:0] SEL_STAT    = 3'd6;

   typedef enum logic {
      W_IDLE = 1'b0,
      W_HOLD = 1'b1
   } wr_state_t;
endpackage

// File: rtl/apple_bridge_responder_if.sv
// Master-side bridge bus: register select, rd/wr strobes and the shared 8-bit data path.
// Read data is combinational from sel/rd_n; writes are single-commit per wr_n low pulse.
interface apple_bridge_responder_if;
   logic [2:0] sel;
   logic       rd_n;
   logic       wr_n;
   logic [7:0] wdata;
   logic       wdata_oe;
   logic [7:0] rdata;
   logic       rdata_oe;

   modport master (output sel, rd_n, wr_n, wdata, wdata_oe, input rdata, rdata_oe);
   modport slave  (input sel, rd_n, wr_n, wdata, wdata_oe, output rdata, rdata_oe);
endinterface

// File: rtl/bridge_sync2.sv
// Parameterised-width two-flop synchronizer; 2-cycle latency, no flow control.
// Reset loads RST_VAL into both stages so idle-high Apple lines read as inactive.
module bridge_sync2 #(
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/apple_bridge_responder.sv
// Apple II bridge responder: combinational read mux (0-cycle), one-commit-per-pulse writes; no backpressure.
// Optional DIP debounce is enabled with `define A2_BRIDGE_DIP_DEBOUNCE_EN.
module apple_bridge_responder
   import apple_bridge_pkg::*;
#(
   parameter logic [15:0] DEBOUNCE_CYCLES   = 16'd50_000,
   parameter logic [7:0]  CONTROL_RESET_VAL = 8'hFF
) (
   input  logic                            clk_logic,
   input  logic                            reset,
   apple_bridge_responder_if.slave         bridge,
   input  logic                            bus_d_oe_n_i,
   input  logic [15:0]                     apple_addr_i,
   input  logic [7:0]                      apple_d_i,
   input  logic                            apple_rw_n_i,
   input  logic                            apple_m2sel_n_i,
   input  logic                            apple_m2b0_i,
   input  logic [7:0]                      gpio_i,
   input  logic [3:0]                      dip_n_i,
   output logic [7:0]                      apple_d_o,
   output logic                            apple_d_oe_o,
   output logic [7:0]                      control_o
);
   logic [26:0] apple_s;
   logic [15:0] addr_s;
   logic [7:0]  d_s;
   logic        rw_s, m2sel_s, m2b0_s;
   logic [7:0]  gpio_s;
   logic [3:0]  dip_s;
   logic [3:0]  dip_reg;
   logic [7:0]  stat_byte;

   bridge_sync2 #(.WIDTH(27), .RST_VAL({16'h0000, 8'h00, 1'b1, 1'b1, 1'b0})) u_sync_apple (
      .clk(clk_logic), .reset(reset),
      .d({apple_addr_i, apple_d_i, apple_rw_n_i, apple_m2sel_n_i, apple_m2b0_i}),
      .q(apple_s));
   bridge_sync2 #(.WIDTH(8), .RST_VAL(8'h00)) u_sync_gpio (
      .clk(clk_logic), .reset(reset), .d(gpio_i), .q(gpio_s));
   bridge_sync2 #(.WIDTH(4), .RST_VAL(4'hF)) u_sync_dip (
      .clk(clk_logic), .reset(reset), .d(dip_n_i), .q(dip_s));

   assign {addr_s, d_s, rw_s, m2sel_s, m2b0_s} = apple_s;

   logic [2:0]  prev_sel;
   logic [15:0] addr_snap;
   logic        rw_snap, m2sel_snap, m2b0_snap;
   logic [7:0]  data_snap;
   logic        load_addr, load_data;

   assign load_addr = (bridge.sel == SEL_ADDR_LO) && (prev_sel != SEL_ADDR_LO);
   assign load_data = (bridge.sel == SEL_DATA) && (prev_sel != SEL_DATA) && !bridge.rd_n;

   always_ff @(posedge clk_logic) begin
      if (reset) begin
         prev_sel   <= SEL_CTRL;
         addr_snap  <= 16'h0000;
         rw_snap    <= 1'b1;
         m2sel_snap <= 1'b1;
         m2b0_snap  <= 1'b0;
         data_snap  <= 8'h00;
      end else begin
         prev_sel <= bridge.sel;
         if (load_addr) begin
            addr_snap  <= addr_s;
            rw_snap    <= rw_s;
            m2sel_snap <= m2sel_s;
            m2b0_snap  <= m2b0_s;
         end
         if (load_data) data_snap <= d_s;
      end
   end

   // The master samples on the same edge that loads a snapshot, so the loading cycle reads the live value.
   logic [15:0] addr_view;
   logic [7:0]  data_view;
   assign addr_view = load_addr ? addr_s : addr_snap;
   assign data_view = load_data ? d_s : data_snap;

   logic [7:0] rd_mux;
   always_comb begin
      rd_mux = 8'hFF;
      case (bridge.sel)
         SEL_CTRL:    rd_mux = gpio_s;
         SEL_DATA:    rd_mux = data_view;
         SEL_ADDR_LO: rd_mux = addr_view[7:0];
         SEL_ADDR_HI: rd_mux = addr_snap[15:8];
         SEL_M2:      rd_mux = {6'b0, m2sel_snap, m2b0_snap};
         SEL_DIP:     rd_mux = {4'hF, dip_reg};
         SEL_STAT:    rd_mux = stat_byte;
         default:     rd_mux = 8'hFF;
      endcase
   end

   assign bridge.rdata_oe = !bridge.rd_n && !bridge.wdata_oe && bridge.wr_n && !reset;
   assign bridge.rdata    = bridge.rdata_oe ? rd_mux : 8'h00;
   assign apple_d_oe_o    = !bus_d_oe_n_i;

   wr_state_t wr_state, wr_state_nxt;
   logic      wr_armed;
   logic      wr_commit;

   // wr_armed blocks a commit when reset releases with wr_n still low.
   always_comb begin
      wr_state_nxt = wr_state;
      wr_commit    = 1'b0;
      case (wr_state)
         W_IDLE: if (!bridge.wr_n && bridge.wdata_oe && wr_armed) begin
            wr_commit    = 1'b1;
            wr_state_nxt = W_HOLD;
         end
         W_HOLD: if (bridge.wr_n) wr_state_nxt = W_IDLE;
         default: wr_state_nxt = W_IDLE;
      endcase
   end

   always_ff @(posedge clk_logic) begin
      if (reset) begin
         wr_state  <= W_IDLE;
         wr_armed  <= bridge.wr_n;
         control_o <= CONTROL_RESET_VAL;
         apple_d_o <= 8'h00;
      end else begin
         wr_state <= wr_state_nxt;
         if (bridge.wr_n) wr_armed <= 1'b1;
         if (wr_commit) begin
            if (bridge.sel == SEL_CTRL) control_o <= bridge.wdata;
            if (bridge.sel == SEL_DATA) apple_d_o <= bridge.wdata;
         end
      end
   end

`ifdef A2_BRIDGE_DIP_DEBOUNCE_EN
   logic [15:0] deb_cnt;
   logic [3:0]  dip_last;
   logic        debounce_busy;

   assign debounce_busy = (dip_s != dip_reg);
   assign stat_byte     = {7'b0, debounce_busy};

   always_ff @(posedge clk_logic) begin
      if (reset) begin
         dip_reg  <= 4'hF;
         dip_last <= 4'hF;
         deb_cnt  <= 16'd0;
      end else begin
         dip_last <= dip_s;
         if (!debounce_busy) begin
            deb_cnt <= 16'd0;
         end else if (dip_s != dip_last) begin
            deb_cnt <= 16'd1;
         end else if (deb_cnt >= DEBOUNCE_CYCLES - 16'd1) begin
            dip_reg <= dip_s;
            deb_cnt <= 16'd0;
         end else begin
            deb_cnt <= deb_cnt + 16'd1;
         end
      end
   end
`else
   assign dip_reg   = dip_s;
   assign stat_byte = 8'hFF;
`endif
endmodule

// File: tb/tb_apple_bridge_responder.sv
// Directed bench for apple_bridge_responder: reads, snapshots, write FSM, reset abort, DIP path.
module tb_apple_bridge_responder;
   logic        clk_logic = 1'b0;
   logic        reset;
   logic        bus_d_oe_n_i;
   logic [15:0] apple_addr_i;
   logic [7:0]  apple_d_i;
   logic        apple_rw_n_i, apple_m2sel_n_i, apple_m2b0_i;
   logic [7:0]  gpio_i;
   logic [3:0]  dip_n_i;
   logic [7:0]  apple_d_o;
   logic        apple_d_oe_o;
   logic [7:0]  control_o;
   int          total = 0;
   int          bad   = 0;

   apple_bridge_responder_if bif ();

   apple_bridge_responder #(.DEBOUNCE_CYCLES(16'd8), .CONTROL_RESET_VAL(8'hFF)) dut (
      .clk_logic(clk_logic), .reset(reset), .bridge(bif.slave),
      .bus_d_oe_n_i(bus_d_oe_n_i), .apple_addr_i(apple_addr_i), .apple_d_i(apple_d_i),
      .apple_rw_n_i(apple_rw_n_i), .apple_m2sel_n_i(apple_m2sel_n_i), .apple_m2b0_i(apple_m2b0_i),
      .gpio_i(gpio_i), .dip_n_i(dip_n_i), .apple_d_o(apple_d_o), .apple_d_oe_o(apple_d_oe_o),
      .control_o(control_o));

   always #5 clk_logic = ~clk_logic;

   task automatic cyc(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_logic);
         #1;
      end
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic idle_bus();
      bif.sel = 3'd7; bif.rd_n = 1'b1; bif.wr_n = 1'b1; bif.wdata = 8'h00; bif.wdata_oe = 1'b0;
   endtask

   task automatic test_reset();
      idle_bus();
      reset = 1'b1; bus_d_oe_n_i = 1'b1;
      apple_addr_i = 16'h0000; apple_d_i = 8'h00; apple_rw_n_i = 1'b1;
      apple_m2sel_n_i = 1'b1; apple_m2b0_i = 1'b0; gpio_i = 8'h00; dip_n_i = 4'hF;
      cyc(3);
      bif.rd_n = 1'b0; bif.sel = 3'd4; settle();
      total++; if (control_o !== 8'hFF) begin bad++; $display("FAIL rst_control got=%h exp=ff", control_o); end
      total++; if (apple_d_o !== 8'h00) begin bad++; $display("FAIL rst_apple_d got=%h exp=00", apple_d_o); end
      total++; if (bif.rdata_oe !== 1'b0 || bif.rdata !== 8'h00) begin bad++; $display("FAIL rst_rd_oe got=%b/%h exp=0/00", bif.rdata_oe, bif.rdata); end
      total++; if (apple_d_oe_o !== 1'b0) begin bad++; $display("FAIL rst_apple_oe got=%b exp=0", apple_d_oe_o); end
      cyc(); reset = 1'b0; settle();
      total++; if (bif.rdata !== 8'h02) begin bad++; $display("FAIL rst_m2_snap got=%h exp=02", bif.rdata); end
      bif.sel = 3'd3; settle();
      total++; if (bif.rdata !== 8'h00) begin bad++; $display("FAIL rst_addr_hi got=%h exp=00", bif.rdata); end
      cyc(); idle_bus();
   endtask

   task automatic test_init();
      bif.sel = 3'd0; bif.wdata = 8'hFF; bif.wdata_oe = 1'b1; bif.wr_n = 1'b0;
      cyc(); idle_bus(); settle();
      total++; if (control_o !== 8'hFF) begin bad++; $display("FAIL init_control got=%h exp=ff", control_o); end
      dip_n_i = 4'b0111;
`ifdef A2_BRIDGE_DIP_DEBOUNCE_EN
      cyc(12);
`else
      cyc(3);
`endif
      bif.sel = 3'd5; bif.rd_n = 1'b0; settle();
      total++; if (bif.rdata !== 8'hF7 || bif.rdata_oe !== 1'b1) begin bad++; $display("FAIL init_dip got=%h/%b exp=f7/1", bif.rdata, bif.rdata_oe); end
      cyc(); idle_bus();
   endtask

   task automatic test_addr_burst();
      apple_addr_i = 16'hC0E3; apple_rw_n_i = 1'b0; apple_m2sel_n_i = 1'b0; apple_m2b0_i = 1'b1; gpio_i = 8'h5A;
      cyc(3);
      bif.sel = 3'd2; bif.rd_n = 1'b0; settle();
      total++; if (bif.rdata !== 8'hE3) begin bad++; $display("FAIL burst_lo got=%h exp=e3", bif.rdata); end
      cyc(); apple_addr_i = 16'h1234; apple_m2sel_n_i = 1'b1; apple_m2b0_i = 1'b0;
      bif.sel = 3'd3; settle();
      total++; if (bif.rdata !== 8'hC0) begin bad++; $display("FAIL burst_hi got=%h exp=c0", bif.rdata); end
      cyc(); bif.sel = 3'd0; settle();
      total++; if (bif.rdata !== 8'h5A) begin bad++; $display("FAIL burst_gpio got=%h exp=5a", bif.rdata); end
      cyc(); bif.sel = 3'd4; settle();
      total++; if (bif.rdata !== 8'h01) begin bad++; $display("FAIL burst_m2 got=%h exp=01", bif.rdata); end
      cyc(3); bif.sel = 3'd3; settle();
      total++; if (bif.rdata !== 8'hC0) begin bad++; $display("FAIL burst_hold_hi got=%h exp=c0", bif.rdata); end
      cyc(); bif.sel = 3'd2; settle();
      total++; if (bif.rdata !== 8'h34) begin bad++; $display("FAIL burst_resample got=%h exp=34", bif.rdata); end
      cyc(); idle_bus();
   endtask

   task automatic test_data_read();
      apple_d_i = 8'h3C; cyc(3);
      bif.sel = 3'd1; bif.rd_n = 1'b0; settle();
      total++; if (bif.rdata !== 8'h3C) begin bad++; $display("FAIL data_rd got=%h exp=3c", bif.rdata); end
      cyc(); apple_d_i = 8'h99; cyc(3); settle();
      total++; if (bif.rdata !== 8'h3C) begin bad++; $display("FAIL data_hold got=%h exp=3c", bif.rdata); end
      cyc(); bif.sel = 3'd7; settle();
      total++; if (bif.rdata !== 8'hFF) begin bad++; $display("FAIL sel7 got=%h exp=ff", bif.rdata); end
      cyc(); bif.sel = 3'd6; settle();
`ifdef A2_BRIDGE_DIP_DEBOUNCE_EN
      total++; if (bif.rdata !== 8'h00) begin bad++; $display("FAIL sel6 got=%h exp=00", bif.rdata); end
`else
      total++; if (bif.rdata !== 8'hFF) begin bad++; $display("FAIL sel6 got=%h exp=ff", bif.rdata); end
`endif
      cyc(); bif.sel = 3'd1; settle();
      total++; if (bif.rdata !== 8'h99) begin bad++; $display("FAIL data_reload got=%h exp=99", bif.rdata); end
      cyc(); idle_bus();
   endtask

   task automatic test_data_write();
      bif.sel = 3'd1; bif.wdata = 8'hA5; bif.wdata_oe = 1'b1; bif.wr_n = 1'b0;
      cyc(); bif.wdata = 8'h11; cyc(2);
      idle_bus(); cyc(); settle();
      total++; if (apple_d_o !== 8'hA5) begin bad++; $display("FAIL wr_single got=%h exp=a5", apple_d_o); end
      total++; if (control_o !== 8'hFF) begin bad++; $display("FAIL wr_ctrl_untouched got=%h exp=ff", control_o); end
      bus_d_oe_n_i = 1'b0; settle();
      total++; if (apple_d_oe_o !== 1'b1) begin bad++; $display("FAIL apple_oe got=%b exp=1", apple_d_oe_o); end
      bus_d_oe_n_i = 1'b1; cyc();
   endtask

   task automatic test_gpio_reset();
      bif.sel = 3'd0; bif.wdata = 8'hFB; bif.wdata_oe = 1'b1; bif.wr_n = 1'b0;
      cyc(); settle();
      total++; if (control_o !== 8'hFB || control_o[2] !== 1'b0) begin bad++; $display("FAIL gpio_wr got=%h exp=fb", control_o); end
      bif.wdata = 8'h00; reset = 1'b1; cyc(); settle();
      total++; if (control_o !== 8'hFF) begin bad++; $display("FAIL gpio_rst got=%h exp=ff", control_o); end
      reset = 1'b0; cyc(2); settle();
      total++; if (control_o !== 8'hFF) begin bad++; $display("FAIL gpio_no_recommit got=%h exp=ff", control_o); end
      bif.wr_n = 1'b1; cyc();
      bif.wr_n = 1'b0; bif.wdata = 8'hFB; cyc(); settle();
      total++; if (control_o !== 8'hFB) begin bad++; $display("FAIL gpio_rearm got=%h exp=fb", control_o); end
      idle_bus(); cyc();
   endtask

   task automatic test_contention();
      bif.sel = 3'd0; bif.rd_n = 1'b0; bif.wdata_oe = 1'b1; settle();
      total++; if (bif.rdata_oe !== 1'b0 || bif.rdata !== 8'h00) begin bad++; $display("FAIL cont_oe got=%b/%h exp=0/00", bif.rdata_oe, bif.rdata); end
      bif.sel = 3'd1; bif.wr_n = 1'b0; bif.wdata = 8'h77; settle();
      total++; if (bif.rdata_oe !== 1'b0) begin bad++; $display("FAIL cont_rdwr_oe got=%b exp=0", bif.rdata_oe); end
      cyc(); settle();
      total++; if (apple_d_o !== 8'h77) begin bad++; $display("FAIL cont_write got=%h exp=77", apple_d_o); end
      idle_bus(); cyc();
      bif.sel = 3'd1; bif.wdata = 8'h42; bif.wr_n = 1'b0; cyc(2); settle();
      total++; if (apple_d_o !== 8'h77) begin bad++; $display("FAIL wr_no_oe got=%h exp=77", apple_d_o); end
      bif.wdata_oe = 1'b1; cyc(); settle();
      total++; if (apple_d_o !== 8'h42) begin bad++; $display("FAIL wr_late_oe got=%h exp=42", apple_d_o); end
      idle_bus(); cyc();
   endtask

`ifdef A2_BRIDGE_DIP_DEBOUNCE_EN
   task automatic test_dip();
      bif.sel = 3'd5; bif.rd_n = 1'b0;
      dip_n_i = 4'b1010; cyc(3);
      dip_n_i = 4'b0101; cyc(3); settle();
      total++; if (bif.rdata !== 8'hF7) begin bad++; $display("FAIL deb_bounce got=%h exp=f7", bif.rdata); end
      dip_n_i = 4'b1010; bif.sel = 3'd6; cyc(5); settle();
      total++; if (bif.rdata !== 8'h01) begin bad++; $display("FAIL deb_busy got=%h exp=01", bif.rdata); end
      bif.sel = 3'd5; cyc(4); settle();
      total++; if (bif.rdata !== 8'hF7) begin bad++; $display("FAIL deb_early got=%h exp=f7", bif.rdata); end
      cyc(); settle();
      total++; if (bif.rdata !== 8'hFA) begin bad++; $display("FAIL deb_update got=%h exp=fa", bif.rdata); end
      bif.sel = 3'd6; settle();
      total++; if (bif.rdata !== 8'h00) begin bad++; $display("FAIL deb_idle got=%h exp=00", bif.rdata); end
      cyc(); idle_bus();
   endtask
`else
   task automatic test_dip();
      bif.sel = 3'd5; bif.rd_n = 1'b0;
      dip_n_i = 4'b1010; settle();
      total++; if (bif.rdata !== 8'hF7) begin bad++; $display("FAIL dip_sync0 got=%h exp=f7", bif.rdata); end
      cyc(); settle();
      total++; if (bif.rdata !== 8'hF7) begin bad++; $display("FAIL dip_sync1 got=%h exp=f7", bif.rdata); end
      cyc(); settle();
      total++; if (bif.rdata !== 8'hFA) begin bad++; $display("FAIL dip_sync2 got=%h exp=fa", bif.rdata); end
      cyc(); idle_bus();
   endtask
`endif

   initial begin
      test_reset();
      test_init();
      test_addr_burst();
      test_data_read();
      test_data_write();
      test_gpio_reset();
      test_contention();
      test_dip();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
